// File: rtl/register_writeback_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// register_writeback_arbiter_pkg
//   Shared types and constants for the register writeback path.
//   - util_math_log2 : ceiling log2 used to size addresses and pointers
//   - util_control_t : clock + synchronous active-high reset bundle
//   - register_wb_t  : one register-file write {addr, data}
// ---------------------------------------------------------------------------
package register_writeback_arbiter_pkg;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int util_math_log2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int DATA_W = 32;
    localparam int ADDR_L = 32;
    localparam int ADDR_W = util_math_log2(ADDR_L);

    typedef struct packed {
        logic clk;
        logic rst;
    } util_control_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } register_wb_t;

endpackage

// File: rtl/register_wb_queue.sv
// ---------------------------------------------------------------------------
// register_wb_queue
//   DEPTH-entry circular FIFO of register writes feeding the writeback
//   arbiter. DEPTH must be a power of two so the pointers wrap for free.
// Ports:
//   ctrl        in   clock + synchronous active-high reset
//   push        in   write push_entry at tail (ignored when full)
//   push_entry  in   entry to enqueue
//   pop         in   retire the head entry (ignored when empty)
//   full        out  DEPTH entries held
//   empty       out  no entries held
//   head        out  oldest entry (meaningful only when !empty)
//   entry_valid out  per-slot occupancy, indexed by storage slot
//   entries     out  raw storage, indexed by storage slot
// ---------------------------------------------------------------------------
module register_wb_queue
    import register_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  util_control_t              ctrl,
    input  logic                       push,
    input  register_wb_t               push_entry,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output register_wb_t               head,
    output logic         [DEPTH-1:0]   entry_valid,
    output register_wb_t [DEPTH-1:0]   entries
);

    localparam int PTR_W = util_math_log2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    register_wb_t [DEPTH-1:0] mem;
    logic [PTR_W-1:0]         head_ptr;
    logic [PTR_W-1:0]         tail_ptr;
    logic [CNT_W-1:0]         count;
    logic                     do_push;
    logic                     do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[head_ptr];
    assign entries = mem;

    // NOTE: storage is deliberately not reset; occupancy is tracked by count,
    // so stale data is never observed and the array maps onto plain flops/RAM.
    always_ff @(posedge ctrl.clk) begin
        if (do_push) begin
            mem[tail_ptr] <= push_entry;
        end
    end

    // NOTE: non-blocking assignments keep every register updating from the
    // same pre-edge values, independent of statement order.
    always_ff @(posedge ctrl.clk) begin
        if (ctrl.rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A slot is occupied when its distance from head is below count.
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] offset;
            offset         = PTR_W'(i) - head_ptr;
            entry_valid[i] = ({1'b0, offset} < count);
        end
    end

endmodule

// File: rtl/register_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// register_writeback_arbiter
//   Merges the in-order pipeline writeback and a queued multi-cycle writeback
//   onto the register file's single write port. The pipeline always wins;
//   the queue drains on idle slots and requests a stall if it starves.
// Ports:
//   ctrl          in   clock + synchronous active-high reset
//   pipe_valid    in   pipeline writeback valid (never back-pressured)
//   pipe_addr     in   pipeline destination register
//   pipe_data     in   pipeline result
//   side_valid    in   multi-cycle result valid
//   side_ready    out  queue can accept this cycle
//   side_addr     in   multi-cycle destination register
//   side_data     in   multi-cycle result
//   wr_addr       out  register file write address
//   wr_data       out  register file write data
//   wr_en         out  register file write enable
//   pending_mask  out  bit r set while a queued write targets r
//   pipe_stall    out  request upstream to hold pipe_valid low
//   waw_err       out  sticky: pipe wrote a register still pending in queue
// ---------------------------------------------------------------------------
module register_writeback_arbiter
    import register_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  util_control_t      ctrl,
    input  logic               pipe_valid,
    input  logic [ADDR_W-1:0]  pipe_addr,
    input  logic [DATA_W-1:0]  pipe_data,
    input  logic               side_valid,
    output logic               side_ready,
    input  logic [ADDR_W-1:0]  side_addr,
    input  logic [DATA_W-1:0]  side_data,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic               wr_en,
    output logic [ADDR_L-1:0]  pending_mask,
    output logic               pipe_stall,
    output logic               waw_err
);

    localparam int                  STARVE_W    = util_math_log2(STARVE_MAX) + 1;
    localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_MAX - 1);

    logic                      q_full;
    logic                      q_empty;
    logic                      q_push;
    logic                      q_pop;
    register_wb_t              q_push_entry;
    register_wb_t              q_head;
    logic         [DEPTH-1:0]  q_entry_valid;
    register_wb_t [DEPTH-1:0]  q_entries;

    logic                      pipe_owns;
    logic                      blocked;
    logic [STARVE_W-1:0]       starve_cnt;

    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign side_ready   = !ctrl.rst && !q_full;
    // Writes to r0 are accepted but discarded: r0 is hardwired.
    assign q_push       = side_valid && side_ready && (side_addr != '0);
    assign q_push_entry = '{addr: side_addr, data: side_data};

    // A pipe write to r0 is an idle slot the queue may use.
    assign pipe_owns    = pipe_valid && (pipe_addr != '0);
    assign blocked      = !q_empty && pipe_owns;

    register_wb_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .ctrl        (ctrl),
        .push        (q_push),
        .push_entry  (q_push_entry),
        .pop         (q_pop),
        .full        (q_full),
        .empty       (q_empty),
        .head        (q_head),
        .entry_valid (q_entry_valid),
        .entries     (q_entries)
    );

    // Write port owner: pipeline, then queue head, else idle.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        q_pop   = 1'b0;
        if (!ctrl.rst) begin
            if (pipe_owns) begin
                wr_en   = 1'b1;
                wr_addr = pipe_addr;
                wr_data = pipe_data;
            end else if (!q_empty) begin
                wr_en   = 1'b1;
                wr_addr = q_head.addr;
                wr_data = q_head.data;
                q_pop   = 1'b1;
            end
        end
    end

    // Registers currently owed a write by the queue; the side input of this
    // cycle is not yet included.
    always_comb begin
        pending_mask = '0;
        if (!ctrl.rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q_entry_valid[i]) begin
                    pending_mask[q_entries[i].addr] = 1'b1;
                end
            end
        end
    end

    // Starvation tracking. The stall is advisory: the counter saturates at
    // its last value so pipe_stall stays up until the head finally pops.
    always_ff @(posedge ctrl.clk) begin
        if (ctrl.rst) begin
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
            waw_err    <= 1'b0;
        end else begin
            if (q_pop || q_empty) begin
                starve_cnt <= '0;
                pipe_stall <= 1'b0;
            end else if (blocked) begin
                if (starve_cnt == STARVE_LAST) begin
                    pipe_stall <= 1'b1;
                end else begin
                    starve_cnt <= starve_cnt + STARVE_W'(1);
                end
            end
            if (pipe_owns && pending_mask[pipe_addr]) begin
                waw_err <= 1'b1;
            end
        end
    end

endmodule
